// File: rtl/ecc_scrub.sv
// Background SECDED scrubber: walks the whole address range, checks every
// 64+8 word, writes corrected words back and logs uncorrectable ones.
// Code layout: extended Hamming code over positions 1..71. Check bit k sits
// at position 2^k, data bits fill the other positions in ascending order, and
// ecc[7] is the overall parity over the data and ecc[6:0].

package ecc_scrub_pkg;
    // Next codeword position after pos that carries a data bit.
    // Starting from 2, this gives 3, 5, 6, 7, 9, ...
    function automatic logic [6:0] next_data_pos(input logic [6:0] pos);
        logic [6:0] p;
        p = pos + 7'd1;
        if ((p & (p - 7'd1)) == 7'd0) p = p + 7'd1;
        return p;
    endfunction

    // XOR of the positions of all set data bits; this equals the Hamming check bits.
    function automatic logic [6:0] ham_par(input logic [63:0] d);
        logic [6:0] pos;
        logic [6:0] par;
        pos = 7'd2;
        par = '0;
        for (int j = 0; j < 64; j++) begin
            pos = next_data_pos(pos);
            if (d[j]) par = par ^ pos;
        end
        return par;
    endfunction
endpackage

// Encoder: one registered stage, loads on in_vld.
module ecc_enc
    import ecc_scrub_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_vld,
    input  logic [63:0] data_in,
    output logic [63:0] data_out,
    output logic [7:0]  ecc_out
);
    logic [6:0] par;
    assign par = ham_par(data_in);

    // Register the data together with its freshly computed check bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out <= '0;
            ecc_out  <= '0;
        end else if (in_vld) begin
            data_out <= data_in;
            ecc_out  <= {^data_in ^ ^par, par};
        end
    end
endmodule

// Decoder: one registered stage. err_sts_out: 00 clean, 01 corrected,
// 10 double error, 11 syndrome outside the codeword.
module ecc_dec
    import ecc_scrub_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_vld,
    input  logic [63:0] data_in,
    input  logic [7:0]  ecc_in,
    output logic [63:0] data_out,
    output logic [1:0]  err_sts_out
);
    logic [6:0]  syn;
    logic        ovr;
    logic        hit;
    logic [6:0]  pos;
    logic [63:0] fixed;
    logic [1:0]  sts;

    // Syndrome, overall parity and single-bit correction.
    always_comb begin
        syn   = ham_par(data_in) ^ ecc_in[6:0];
        ovr   = ^{data_in, ecc_in};
        fixed = data_in;
        hit   = 1'b0;
        pos   = 7'd2;
        sts   = 2'b00;
        for (int j = 0; j < 64; j++) begin
            pos = next_data_pos(pos);
            if (ovr && pos == syn) begin
                fixed[j] = ~data_in[j];
                hit      = 1'b1;
            end
        end
        if (ovr) begin
            // syn of zero or a power of two means a check bit flipped: data is already good.
            if (!hit && (syn & (syn - 7'd1)) != 7'd0) sts = 2'b11;
            else                                       sts = 2'b01;
        end else if (syn != 7'd0) begin
            sts = 2'b10;
        end
    end

    // Register the corrected word and its status.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out    <= '0;
            err_sts_out <= '0;
        end else if (in_vld) begin
            data_out    <= fixed;
            err_sts_out <= sts;
        end
    end
endmodule

module ecc_scrub #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int ECC_WIDTH  = 8,
    parameter int GAP_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [GAP_WIDTH-1:0]  gap,
    input  logic                  clr_cnt,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ECC_WIDTH-1:0]  mem_wecc,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [ECC_WIDTH-1:0]  mem_recc,
    output logic [15:0]           corr_cnt,
    output logic [15:0]           uncorr_cnt,
    output logic                  err_vld,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic                  err_irq
);
    typedef enum logic [2:0] {IDLE, GAP, RD, RWAIT, DEC, ENC, WR, NEXT} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [GAP_WIDTH-1:0]  gap_load_reg;
    logic [GAP_WIDTH-1:0]  gap_cnt_reg;
    logic                  abort_pend_reg;
    logic                  done_reg;
    logic [15:0]           corr_reg;
    logic [15:0]           uncorr_reg;
    logic                  err_vld_reg;
    logic [ADDR_WIDTH-1:0] err_addr_reg;
    logic                  err_irq_reg;

    logic [63:0] dec_data;
    logic [1:0]  dec_sts;
    logic        dec_in_vld;
    logic        enc_in_vld;
    logic        take_corr;
    logic        take_uncorr;

    assign dec_in_vld  = (state_reg == RWAIT) && mem_rvalid;
    assign take_corr   = (state_reg == DEC) && (dec_sts == 2'b01);
    assign take_uncorr = (state_reg == DEC) && dec_sts[1];
    assign enc_in_vld  = take_corr;

    ecc_dec u_dec (
        .clk         (clk),
        .rstn        (rstn),
        .in_vld      (dec_in_vld),
        .data_in     (mem_rdata),
        .ecc_in      (mem_recc),
        .data_out    (dec_data),
        .err_sts_out (dec_sts)
    );

    ecc_enc u_enc (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (enc_in_vld),
        .data_in  (dec_data),
        .data_out (mem_wdata),
        .ecc_out  (mem_wecc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state and memory request decode.
    always_comb begin
        state_next = state_reg;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE:  if (start) state_next = GAP;
            GAP: begin
                if (abort_pend_reg)            state_next = IDLE;
                else if (gap_cnt_reg == '0)    state_next = RD;
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_gnt) state_next = RWAIT;
            end
            RWAIT: if (mem_rvalid) state_next = DEC;
            DEC:   state_next = take_corr ? ENC : NEXT;
            ENC:   state_next = WR;
            WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_gnt) state_next = NEXT;
            end
            NEXT: begin
                if ((&addr_reg) || abort_pend_reg) state_next = IDLE;
                else                               state_next = GAP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address walk, gap counter, abort latch and done pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_reg       <= '0;
            gap_load_reg   <= '0;
            gap_cnt_reg    <= '0;
            abort_pend_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= (state_reg != IDLE) && (state_next == IDLE);
            if (state_reg == IDLE && start) begin
                addr_reg     <= '0;
                gap_load_reg <= gap;
                gap_cnt_reg  <= gap;
            end else if (state_reg == GAP && gap_cnt_reg != '0) begin
                gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
            end else if (state_reg == NEXT && state_next == GAP) begin
                addr_reg    <= addr_reg + ADDR_WIDTH'(1);
                gap_cnt_reg <= gap_load_reg;
            end
            if (state_reg == IDLE) abort_pend_reg <= 1'b0;
            else if (abort)        abort_pend_reg <= 1'b1;
        end
    end

    // Error statistics; clr_cnt overrides a same-cycle update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            corr_reg     <= '0;
            uncorr_reg   <= '0;
            err_vld_reg  <= 1'b0;
            err_addr_reg <= '0;
            err_irq_reg  <= 1'b0;
        end else begin
            err_irq_reg <= take_uncorr;
            if (take_uncorr) err_addr_reg <= addr_reg;
            if (clr_cnt) begin
                corr_reg    <= '0;
                uncorr_reg  <= '0;
                err_vld_reg <= 1'b0;
            end else begin
                if (take_corr && corr_reg != 16'hFFFF)     corr_reg   <= corr_reg + 16'd1;
                if (take_uncorr && uncorr_reg != 16'hFFFF) uncorr_reg <= uncorr_reg + 16'd1;
                if (take_uncorr)                           err_vld_reg <= 1'b1;
            end
        end
    end

    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign mem_addr   = addr_reg;
    assign corr_cnt   = corr_reg;
    assign uncorr_cnt = uncorr_reg;
    assign err_vld    = err_vld_reg;
    assign err_addr   = err_addr_reg;
    assign err_irq    = err_irq_reg;
endmodule
